// File: rtl/server_fsm_pkg.sv
// Shared types and constants for the server control FSM: state encoding,
// request-frame field positions and the default authentication key.
package server_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        AUTH  = 2'b01,
        GRANT = 2'b10,
        OP    = 2'b11
    } state_e;

    localparam int FRAME_W  = 16;
    localparam int FLAG_BIT = 15;
    localparam int KEY_MSB  = 14;
    localparam int KEY_LSB  = 12;
    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [2:0] AUTH_KEY_DEFAULT = 3'b101;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/server_fsm_if.sv
// User/OPU-facing signal bundle of server_fsm. auth_err exists only when
// SERVER_FSM_AUTH_ERR_EN is defined.
interface server_fsm_if;
    import server_fsm_pkg::*;

    logic               start;
    logic [FRAME_W-1:0] frame;
    logic               auth_done;
    logic [1:0]         op_code;
    logic [7:0]         data;
    logic               op_start;
    logic               op_done;
`ifdef SERVER_FSM_AUTH_ERR_EN
    logic               auth_err;

    modport master (output start, frame, op_done,
                    input  auth_done, op_code, data, op_start, auth_err);
    modport slave  (input  start, frame, op_done,
                    output auth_done, op_code, data, op_start, auth_err);
`else
    modport master (output start, frame, op_done,
                    input  auth_done, op_code, data, op_start);
    modport slave  (input  start, frame, op_done,
                    output auth_done, op_code, data, op_start);
`endif

endinterface

// File: rtl/server_frame_check.sv
// Combinational frame authentication: processed flag clear, key match and a
// one-hot op field, plus the one-hot to binary op encoder.
module server_frame_check
    import server_fsm_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    input  logic [2:0]         key,
    output logic               valid,
    output logic [1:0]         op_code
);

    logic [3:0] op_field;

    assign op_field = frame[OP_MSB:OP_LSB];

    // Validity check and op encoder; invalid fields encode to 0 and are never used.
    always_comb begin
        valid = (frame[FLAG_BIT] == 1'b0)
             && (frame[KEY_MSB:KEY_LSB] == key)
             && is_onehot4(op_field);
        case (op_field)
            4'b0001: op_code = 2'd0;
            4'b0010: op_code = 2'd1;
            4'b0100: op_code = 2'd2;
            4'b1000: op_code = 2'd3;
            default: op_code = 2'd0;
        endcase
    end

endmodule

// File: rtl/server_fsm.sv
// Server control FSM: latches a request frame, authenticates it, dispatches
// op_code/data to the OPU and waits for op_done. Optional: SERVER_FSM_AUTH_ERR_EN.
module server_fsm
    import server_fsm_pkg::*;
#(
    parameter logic [2:0] AUTH_KEY = AUTH_KEY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    server_fsm_if.slave bus
);

    state_e             current_state;
    state_e             next_state;
    logic [FRAME_W-1:0] frame_q,     frame_d;
    logic               auth_done_q, auth_done_d;
    logic               op_start_q,  op_start_d;
    logic [1:0]         op_code_q,   op_code_d;
    logic [7:0]         data_q,      data_d;
    logic               chk_valid;
    logic [1:0]         chk_op_code;
`ifdef SERVER_FSM_AUTH_ERR_EN
    logic               auth_err_q,  auth_err_d;
`endif

    server_frame_check u_frame_check (
        .frame   (frame_q),
        .key     (AUTH_KEY),
        .valid   (chk_valid),
        .op_code (chk_op_code)
    );

    // Next-state and next-output logic; outputs are decoded from the state being entered.
    always_comb begin
        next_state = current_state;
        frame_d    = frame_q;
        op_code_d  = op_code_q;
        data_d     = data_q;
`ifdef SERVER_FSM_AUTH_ERR_EN
        auth_err_d = 1'b0;
`endif
        case (current_state)
            IDLE: begin
                if (bus.start) begin
                    frame_d    = bus.frame;
                    next_state = AUTH;
                end else begin
                    next_state = IDLE;
                end
            end
            AUTH: begin
                if (chk_valid) begin
                    next_state = GRANT;
                    op_code_d  = chk_op_code;
                    data_d     = frame_q[DATA_MSB:DATA_LSB];
                end else begin
                    // Rejected frames leave the dispatched op_code/data untouched.
                    next_state = IDLE;
`ifdef SERVER_FSM_AUTH_ERR_EN
                    auth_err_d = 1'b1;
`endif
                end
            end
            GRANT: begin
                next_state = OP;
            end
            OP: begin
                if (bus.op_done) begin
                    next_state = IDLE;
                end else begin
                    next_state = OP;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        auth_done_d = (next_state == GRANT);
        op_start_d  = (next_state == OP);
    end

    // State register, frame latch and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= IDLE;
            frame_q       <= '0;
            auth_done_q   <= 1'b0;
            op_start_q    <= 1'b0;
            op_code_q     <= 2'd0;
            data_q        <= 8'd0;
`ifdef SERVER_FSM_AUTH_ERR_EN
            auth_err_q    <= 1'b0;
`endif
        end else begin
            current_state <= next_state;
            frame_q       <= frame_d;
            auth_done_q   <= auth_done_d;
            op_start_q    <= op_start_d;
            op_code_q     <= op_code_d;
            data_q        <= data_d;
`ifdef SERVER_FSM_AUTH_ERR_EN
            auth_err_q    <= auth_err_d;
`endif
        end
    end

    assign bus.auth_done = auth_done_q;
    assign bus.op_start  = op_start_q;
    assign bus.op_code   = op_code_q;
    assign bus.data      = data_q;
`ifdef SERVER_FSM_AUTH_ERR_EN
    assign bus.auth_err  = auth_err_q;
`endif

endmodule

// File: tb/tb_server_fsm.sv
// Self-checking bench for server_fsm: directed frame table, random frames
// against a frame-acceptance model, and reset/ignored-input corner cases.
module tb_server_fsm;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [1:0] held_code;
    logic [7:0] held_data;

    server_fsm_if bus ();

    server_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        bit          exp_valid;
        logic [1:0]  exp_code;
        int          op_wait;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Acceptance rule from the frame format: flag clear, key 5, exactly one op bit.
    function automatic bit ref_accept(input logic [15:0] f, output logic [1:0] code);
        int n;
        n    = 0;
        code = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (f[8+b]) begin
                n++;
                code = 2'(b);
            end
        end
        return (f[15] == 1'b0) && (f[14:12] == 3'd5) && (n == 1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.op_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_state", dut.current_state, 2'b00);
            chk("idle_auth_done", bus.auth_done, 1'b0);
            chk("idle_op_start", bus.op_start, 1'b0);
        end
        bus.op_done = 1'b0;
    endtask

    // One frame from IDLE to IDLE; called right after a falling edge.
    task automatic do_frame(input logic [15:0] f, input bit exp_valid, input logic [1:0] exp_code,
                            input int op_wait, input bit spur_start, input bit done_with_start);
        bus.frame   = f;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.frame   = 16'($urandom);
        bus.start   = spur_start;
        chk("auth_state", dut.current_state, 2'b01);
        chk("auth_auth_done", bus.auth_done, 1'b0);
        chk("auth_op_start", bus.op_start, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        if (exp_valid) begin
            held_code = exp_code;
            held_data = f[7:0];
            chk("grant_state", dut.current_state, 2'b10);
            chk("grant_auth_done", bus.auth_done, 1'b1);
            chk("grant_op_start", bus.op_start, 1'b0);
            chk("grant_op_code", bus.op_code, held_code);
            chk("grant_data", bus.data, held_data);
`ifdef SERVER_FSM_AUTH_ERR_EN
            chk("grant_auth_err", bus.auth_err, 1'b0);
`endif
            bus.start = spur_start;
            @(negedge clk);
            bus.start = 1'b0;
            chk("op_state", dut.current_state, 2'b11);
            chk("op_auth_done", bus.auth_done, 1'b0);
            chk("op_op_start", bus.op_start, 1'b1);
            for (int i = 0; i < op_wait; i++) begin
                bus.start = spur_start;
                bus.frame = 16'($urandom);
                @(negedge clk);
                bus.start = 1'b0;
                chk("op_hold_state", dut.current_state, 2'b11);
                chk("op_hold_op_start", bus.op_start, 1'b1);
                chk("op_hold_op_code", bus.op_code, held_code);
                chk("op_hold_data", bus.data, held_data);
            end
            bus.op_done = 1'b1;
            bus.start   = done_with_start;
            @(negedge clk);
            bus.op_done = 1'b0;
            bus.start   = 1'b0;
            chk("done_state", dut.current_state, 2'b00);
            chk("done_op_start", bus.op_start, 1'b0);
            chk("done_auth_done", bus.auth_done, 1'b0);
        end else begin
            chk("reject_state", dut.current_state, 2'b00);
            chk("reject_auth_done", bus.auth_done, 1'b0);
            chk("reject_op_start", bus.op_start, 1'b0);
            chk("reject_op_code", bus.op_code, held_code);
            chk("reject_data", bus.data, held_data);
`ifdef SERVER_FSM_AUTH_ERR_EN
            chk("reject_auth_err", bus.auth_err, 1'b1);
`endif
        end
        @(negedge clk);
        chk("after_state", dut.current_state, 2'b00);
        chk("after_op_code", bus.op_code, held_code);
        chk("after_data", bus.data, held_data);
`ifdef SERVER_FSM_AUTH_ERR_EN
        chk("after_auth_err", bus.auth_err, 1'b0);
`endif
    endtask

    initial begin
        logic [15:0] f;
        logic [1:0]  code;
        bit          ok;

        tests       = 0;
        fails       = 0;
        held_code   = 2'd0;
        held_data   = 8'd0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.frame   = 16'd0;
        bus.op_done = 1'b0;

        vecs[0] = '{16'h52CC, 1'b1, 2'd1, 1};
        vecs[1] = '{16'h6155, 1'b0, 2'd0, 0};
        vecs[2] = '{16'h55F0, 1'b0, 2'd0, 0};
        vecs[3] = '{16'h5133, 1'b1, 2'd0, 10};
        vecs[4] = '{16'hD801, 1'b0, 2'd0, 0};
        vecs[5] = '{16'h5801, 1'b1, 2'd3, 0};
        vecs[6] = '{16'h5000, 1'b0, 2'd0, 0};
        vecs[7] = '{16'h54AA, 1'b1, 2'd2, 3};
        vecs[8] = '{16'h7201, 1'b0, 2'd0, 0};

        #12;
        chk("reset_state", dut.current_state, 2'b00);
        chk("reset_auth_done", bus.auth_done, 1'b0);
        chk("reset_op_start", bus.op_start, 1'b0);
        chk("reset_op_code", bus.op_code, 2'd0);
        chk("reset_data", bus.data, 8'd0);
`ifdef SERVER_FSM_AUTH_ERR_EN
        chk("reset_auth_err", bus.auth_err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            do_frame(vecs[i].frame, vecs[i].exp_valid, vecs[i].exp_code,
                     vecs[i].op_wait, 1'b1, 1'b1);
            idle(5);
        end

        // Asynchronous reset while the OPU is busy.
        do_frame(16'h5233, 1'b1, 2'd1, 0, 1'b0, 1'b0);
        bus.frame = 16'h52EE;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        chk("pre_rst_op_start", bus.op_start, 1'b1);
        chk("pre_rst_data", bus.data, 8'hEE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", dut.current_state, 2'b00);
        chk("async_rst_op_start", bus.op_start, 1'b0);
        chk("async_rst_auth_done", bus.auth_done, 1'b0);
        chk("async_rst_op_code", bus.op_code, 2'd0);
        chk("async_rst_data", bus.data, 8'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        held_code = 2'd0;
        held_data = 8'd0;
        idle(2);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                f = {1'b0, 3'b101, 4'(1 << $urandom_range(0, 3)), 8'($urandom)};
            end else begin
                f = 16'($urandom);
            end
            ok = ref_accept(f, code);
            do_frame(f, ok, code, int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
